dff_rst_en: RTL and testbench



---
 rtl/dff_rst_en.sv | 34 +++
 tb/tb_dff_rst_en.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/dff_rst_en.sv
// rtl/dff_rst_en.sv - D flip-flop with asynchronous active-high reset and load enable
//
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous reset, active-high; forces q to RESET_VALUE immediately
//   en  : load enable, active-high; q takes d at a rising clk edge when set
//   d   : WIDTH-bit data to capture
//   q   : WIDTH-bit registered state (no combinational path from d or en)

module dff_rst_en #(
    parameter int              WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    // Reset outranks the enable; with en low the register simply holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= RESET_VALUE;
        end else if (en) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule

// File: tb/tb_dff_rst_en.sv
// tb/tb_dff_rst_en.sv - scoreboard bench for dff_rst_en (1-bit and 8-bit instances)
`timescale 1ns/10ps

module tb_dff_rst_en;

    localparam logic [7:0] RV8 = 8'hA5;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       d;
    logic       q;
    logic       en8;
    logic [7:0] d8;
    logic [7:0] q8;

    always #5 clk = ~clk;

    dff_rst_en u_dut1 (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .d   (d),
        .q   (q)
    );

    dff_rst_en #(
        .WIDTH       (8),
        .RESET_VALUE (RV8)
    ) u_dut8 (
        .clk (clk),
        .rst (rst),
        .en  (en8),
        .d   (d8),
        .q   (q8)
    );

    typedef struct {
        logic       exp1;
        logic [7:0] exp8;
        string      name;
    } exp_t;

    exp_t sb[$];
    event ev_chk;
    int   checks = 0;
    int   errors = 0;

    // Reference model: the value each register should hold right now.
    logic       m1;
    logic [7:0] m8;

    // Monitor: drains the scoreboard whenever the stimulus presents a sample point.
    initial begin
        exp_t e;
        forever begin
            @(ev_chk);
            while (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                if (q !== e.exp1) begin
                    errors++;
                    $display("FAIL %s w1: q=%b expected=%b at %0t", e.name, q, e.exp1, $time);
                end
                checks++;
                if (q8 !== e.exp8) begin
                    errors++;
                    $display("FAIL %s w8: q=%h expected=%h at %0t", e.name, q8, e.exp8, $time);
                end
            end
        end
    end

    task automatic expect_now(input string name);
        sb.push_back('{m1, m8, name});
        -> ev_chk;
        #0.2;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s monitor: pending=%0d expected=0", name, sb.size());
            sb.delete();
        end
    endtask

    // Async reset takes effect the moment rst rises.
    task automatic set_rst(input logic v);
        rst = v;
        if (v) begin
            m1 = 1'b0;
            m8 = RV8;
        end
    endtask

    // One rising edge: apply the spec rules to the inputs present at the edge.
    task automatic step();
        if (rst) begin
            m1 = 1'b0;
            m8 = RV8;
        end else begin
            if (en)  m1 = d;
            if (en8) m8 = d8;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic dv, input logic [7:0] dv8);
        en  = e;
        en8 = e;
        d   = dv;
        d8  = dv8;
    endtask

    initial begin
        logic pat [5];
        pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        rst = 1'b0;
        drive(1'b0, 1'b0, 8'h00);
        m1 = 1'bx;
        m8 = 8'hxx;
        #2;

        // Basic
        set_rst(1'b1);
        step();
        expect_now("basic_rst");
        set_rst(1'b0);
        drive(1'b1, 1'b1, 8'h3C);
        step();
        expect_now("basic_load1");
        drive(1'b1, 1'b0, 8'hC3);
        step();
        expect_now("basic_load0");

        // Directed reset with en=1 and priority over load
        drive(1'b1, 1'b1, 8'h5A);
        step();
        expect_now("rst_preload");
        set_rst(1'b1);
        step();
        expect_now("rst_prio");
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, i[0], 8'($urandom));
            step();
            expect_now("rst_hold");
        end
        drive(1'b0, 1'b1, 8'hFF);
        set_rst(1'b0);
        #1;
        expect_now("rst_release");
        step();
        expect_now("rst_release_edge");

        // en=1 sequence
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, pat[i], 8'($urandom));
            step();
            expect_now("en1_seq");
        end

        // en=0 hold with q=1 then q=0
        for (int v = 1; v >= 0; v--) begin
            drive(1'b1, v[0], v[0] ? 8'hF0 : 8'h0F);
            step();
            expect_now("en0_load");
            for (int i = 0; i < 3; i++) begin
                drive(1'b0, i[0], 8'($urandom));
                step();
                expect_now("en0_hold");
            end
        end

        // Mid-cycle changes and falling edge
        drive(1'b1, 1'b1, 8'h81);
        step();
        expect_now("mid_load");
        drive(1'b1, 1'b0, 8'h7E);
        #1;
        expect_now("mid_toggle_a");
        drive(1'b0, 1'b1, 8'h11);
        #1;
        expect_now("mid_toggle_b");
        drive(1'b1, ~m1, ~m8);
        @(negedge clk);
        #1;
        expect_now("falling_edge");
        drive(1'b0, 1'b0, 8'h00);
        step();
        expect_now("after_falling_hold");

        // Asynchronous reset between edges
        drive(1'b1, 1'b1, 8'h42);
        step();
        drive(1'b0, 1'b1, 8'h42);
        expect_now("async_preload");
        @(negedge clk);
        #2;
        set_rst(1'b1);
        #0.5;
        expect_now("async_rst");
        set_rst(1'b0);
        #0.5;
        expect_now("async_release");
        step();
        expect_now("async_after_edge");

        // Randomized traffic
        for (int i = 0; i < 200; i++) begin
            set_rst($urandom_range(0, 15) == 0);
            en  = 1'($urandom);
            en8 = 1'($urandom);
            d   = 1'($urandom);
            d8  = 8'($urandom);
            step();
            expect_now("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
